// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin front end that lets several requesters share
// one aes256_enc core. It captures the winner's operands, runs the core's
// start/ready handshake under a timeout, and returns the ciphertext to the
// owner over a valid/ready response.
module aes_core_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*256-1:0] req_key,
  input  logic [NUM_REQ*128-1:0] req_text,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [127:0]           resp_data,
  output logic                   resp_err,
  output logic                   core_start,
  output logic [255:0]           core_key,
  output logic [127:0]           core_text,
  input  logic [127:0]           core_data_out,
  input  logic                   core_ready,
  output logic                   busy
);

  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   last_owner;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   cand;
  logic            pick_valid;
  logic [255:0]    key_arr  [NUM_REQ];
  logic [127:0]    text_arr [NUM_REQ];

  // Split the flat operand buses into per-requester slots.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign key_arr[g]  = req_key[g*256 +: 256];
    assign text_arr[g] = req_text[g*128 +: 128];
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan from farthest to nearest offset after the last
  // owner so the nearest pending requester is the one left in 'pick'.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PW'((int'(last_owner) + k) % NUM_REQ);
      if (req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Job sequencer: grant, operand settle, core start, wait with timeout, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      core_start <= 1'b0;
      core_key   <= '0;
      core_text  <= '0;
      busy       <= 1'b0;
      owner      <= '0;
      last_owner <= PW'(NUM_REQ - 1);
      timer      <= '0;
    end else begin
      grant      <= '0;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            core_key  <= key_arr[pick];
            core_text <= text_arr[pick];
            owner     <= pick;
            grant     <= onehot(pick);
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          state <= START;
        end
        START: begin
          core_start <= 1'b1;
          timer      <= '0;
          state      <= BUSY;
        end
        BUSY: begin
          if (timer != TW'(TIMEOUT)) begin
            timer <= timer + 1'b1;
          end
          if (timer != '0 && core_ready) begin
            resp_data  <= core_data_out;
            resp_err   <= 1'b0;
            resp_valid <= onehot(owner);
            state      <= DONE;
          end else if (timer == TW'(TIMEOUT)) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= onehot(owner);
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready[owner]) begin
            resp_valid <= '0;
            last_owner <= owner;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
